// File: rtl/l2_cache.sv
// l2_cache
//   Direct-mapped, write-back, write-allocate L2 cache that sits between an
//   L1 cache and slow memory. Lines are 128 bits (4 words) and addresses are
//   line addresses. All storage is held in registers.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   proc_read/proc_write   L1 line read / line write, held until proc_ready
//   proc_addr[27:0]        line address: [IDX_W-1:0] index, upper bits tag
//   proc_wdata[127:0]      line write data
//   proc_rdata[127:0]      line read data, valid while proc_ready=1
//   proc_ready             request completes this cycle (combinational)
//   mem_read/mem_write     registered memory line read / write strobes
//   mem_addr[27:0]         registered memory line address
//   mem_wdata[127:0]       registered memory write data
//   mem_rdata[127:0]       memory read data, sampled on mem_ready
//   mem_ready              memory transfer complete
module l2_cache #(
    parameter int IDX_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [27:0]  proc_addr,
    input  logic [127:0] proc_wdata,
    output logic [127:0] proc_rdata,
    output logic         proc_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int NUM_LINES = 2 ** IDX_W;
    localparam int TAG_W     = 28 - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic             valid_r [NUM_LINES];
    logic             dirty_r [NUM_LINES];
    logic [TAG_W-1:0] tag_r   [NUM_LINES];
    logic [127:0]     data_r  [NUM_LINES];

    logic             mem_read_r;
    logic             mem_write_r;
    logic [27:0]      mem_addr_r;
    logic [127:0]     mem_wdata_r;

    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic             req_s;
    logic             hit_s;
    logic             victim_dirty_s;
    logic             hit_write_s;
    logic             fill_s;

    assign idx_s          = proc_addr[IDX_W-1:0];
    assign tag_s          = proc_addr[27:IDX_W];
    assign req_s          = proc_read | proc_write;
    assign hit_s          = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign victim_dirty_s = valid_r[idx_s] && dirty_r[idx_s];
    // A simultaneous read+write is handled as a write.
    assign hit_write_s    = (state_r == ST_IDLE) && proc_write && hit_s;
    assign fill_s         = (state_r == ST_ALLOCATE) && mem_ready;

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: a miss evicts a dirty victim first, then fills.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && !hit_s) begin
                    if (victim_dirty_s) begin
                        state_s = ST_WRITEBACK;
                    end else begin
                        state_s = ST_ALLOCATE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ready) begin
                    state_s = ST_ALLOCATE;
                end else begin
                    state_s = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ALLOCATE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Processor-side outputs: zero-cycle hit response only from IDLE.
    always_comb begin
        proc_rdata = data_r[idx_s];
        if ((state_r == ST_IDLE) && req_s && hit_s) begin
            proc_ready = 1'b1;
        end else begin
            proc_ready = 1'b0;
        end
    end

    // Memory-side outputs are registered from the next state so they are
    // stable for the whole transfer; address/data load only on phase entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 28'd0;
            mem_wdata_r <= 128'd0;
        end else begin
            mem_read_r  <= (state_s == ST_ALLOCATE);
            mem_write_r <= (state_s == ST_WRITEBACK);
            if ((state_s == ST_WRITEBACK) && (state_r == ST_IDLE)) begin
                mem_addr_r  <= {tag_r[idx_s], idx_s};
                mem_wdata_r <= data_r[idx_s];
            end else if ((state_s == ST_ALLOCATE) && (state_r != ST_ALLOCATE)) begin
                mem_addr_r  <= proc_addr;
            end else begin
                mem_addr_r  <= mem_addr_r;
            end
        end
    end

    // Line status bits; cleared by reset so every line misses afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                valid_r[i] <= 1'b0;
                dirty_r[i] <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_write_s) begin
                        dirty_r[idx_s] <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        dirty_r[idx_s] <= 1'b0;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                    end
                end
                default: begin
                    valid_r[idx_s] <= valid_r[idx_s];
                end
            endcase
        end
    end

    // Tag and data arrays; contents are qualified by valid_r so need no reset.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            data_r[idx_s] <= mem_rdata;
            tag_r[idx_s]  <= tag_s;
        end else if (hit_write_s) begin
            data_r[idx_s] <= proc_wdata;
        end
    end

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache
//   Self-checking bench for l2_cache. A transaction-level model (line arrays
//   plus a sparse memory image) predicts every cycle of each request; one
//   compare loop checks the DUT on each falling edge against those
//   predictions, and a few literal checks pin the model to known values.
module tb_l2_cache;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [27:0]  proc_addr;
    logic [127:0] proc_wdata;
    logic [127:0] proc_rdata;
    logic         proc_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    l2_cache #(.IDX_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_ready (proc_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit           m_valid [64];
    bit           m_dirty [64];
    logic [21:0]  m_tag   [64];
    logic [127:0] m_data  [64];
    logic [127:0] mem_img [logic [27:0]];

    int n_tests;
    int n_fail;

    // Per-cycle expectations consumed by the compare loop
    bit           e_en, e_ready, e_mrd, e_mwr, e_addr_en, e_wd_en, e_rd_en;
    logic [27:0]  e_addr;
    logic [127:0] e_wd, e_rd;

    // Observations recorded by the compare loop
    logic [127:0] last_rdata;
    logic [27:0]  last_wb_addr;
    logic [127:0] last_wb_data;
    int           n_wb, n_fill;

    function automatic logic [127:0] mem_get(input logic [27:0] a);
        if (mem_img.exists(a)) begin
            return mem_img[a];
        end
        return {a, 4'h5, a, 4'hC, a, 4'h3, a, 4'h9};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_exp(input bit rdy, input bit mrd, input bit mwr,
                           input bit aen, input logic [27:0] a,
                           input bit wen, input logic [127:0] wd,
                           input bit ren, input logic [127:0] rd);
        e_en = 1'b1; e_ready = rdy; e_mrd = mrd; e_mwr = mwr;
        e_addr_en = aen; e_addr = a; e_wd_en = wen; e_wd = wd;
        e_rd_en = ren; e_rd = rd;
    endtask

    task automatic set_idle();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0, 128'd0, 1'b0, 128'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One processor request, predicted cycle by cycle from the model.
    task automatic do_req(input bit rd, input bit wr, input logic [27:0] addr,
                          input logic [127:0] wdata);
        logic [5:0]   idx;
        logic [21:0]  tag;
        logic [27:0]  wa;
        logic [127:0] wd, fd;
        bit           hit;
        int           lat;
        idx = addr[5:0];
        tag = addr[27:6];
        hit = m_valid[idx] && (m_tag[idx] == tag);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wdata;
        if (!hit) begin
            set_idle();
            step();
            if (m_valid[idx] && m_dirty[idx]) begin
                wa  = {m_tag[idx], idx};
                wd  = m_data[idx];
                lat = $urandom_range(0, 3);
                for (int k = 0; k <= lat; k++) begin
                    mem_ready = (k == lat);
                    set_exp(1'b0, 1'b0, 1'b1, 1'b1, wa, 1'b1, wd, 1'b0, 128'd0);
                    step();
                end
                mem_ready = 1'b0;
                mem_img[wa] = wd;
                m_dirty[idx] = 1'b0;
            end
            fd  = mem_get(addr);
            lat = $urandom_range(0, 3);
            for (int k = 0; k <= lat; k++) begin
                mem_ready = (k == lat);
                mem_rdata = (k == lat) ? fd : {$urandom, $urandom, $urandom, $urandom};
                set_exp(1'b0, 1'b1, 1'b0, 1'b1, addr, 1'b0, 128'd0, 1'b0, 128'd0);
                step();
            end
            mem_ready = 1'b0;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_data[idx]  = fd;
        end
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0, 128'd0, !wr, m_data[idx]);
        step();
        if (wr) begin
            m_data[idx]  = wdata;
            m_dirty[idx] = 1'b1;
        end
        proc_read  = 1'b0;
        proc_write = 1'b0;
        set_idle();
    endtask

    initial begin
        int nf, nw, r;
        logic [5:0]  ri;
        logic [21:0] rt;
        n_tests = 0; n_fail = 0; n_wb = 0; n_fill = 0;
        e_en = 1'b0; e_ready = 1'b0; e_mrd = 1'b0; e_mwr = 1'b0;
        e_addr_en = 1'b0; e_wd_en = 1'b0; e_rd_en = 1'b0;
        e_addr = 28'd0; e_wd = 128'd0; e_rd = 128'd0;
        last_rdata = 128'd0; last_wb_addr = 28'd0; last_wb_data = 128'd0;
        rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = 28'd0; proc_wdata = 128'd0; mem_rdata = 128'd0; mem_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 22'd0; m_data[i] = 128'd0;
        end

        // Compare loop: checks the DUT against the model every falling edge.
        fork
            forever begin
                @(negedge clk);
                if (e_en) begin
                    chk("proc_ready", {127'd0, proc_ready}, {127'd0, e_ready});
                    chk("mem_read",   {127'd0, mem_read},   {127'd0, e_mrd});
                    chk("mem_write",  {127'd0, mem_write},  {127'd0, e_mwr});
                    if (e_addr_en) chk("mem_addr",   {100'd0, mem_addr}, {100'd0, e_addr});
                    if (e_wd_en)   chk("mem_wdata",  mem_wdata, e_wd);
                    if (e_rd_en)   chk("proc_rdata", proc_rdata, e_rd);
                end
                if (proc_ready && proc_read && !proc_write) last_rdata = proc_rdata;
                if (mem_ready && mem_write) begin
                    n_wb++;
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                end
                if (mem_ready && mem_read) n_fill++;
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Reset state: memory outputs zeroed, no response without request
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 28'd0, 1'b1, 128'd0, 1'b0, 128'd0);
        step();
        set_idle();

        mem_img[28'h0000010] = {32{4'hA}};
        mem_img[28'h0000050] = {32{4'h5}};

        // 1: cold read miss fills from memory, no writeback
        do_req(1'b1, 1'b0, 28'h0000010, 128'd0);
        chk("t1_rdata", last_rdata, {32{4'hA}});
        chk("t1_no_wb", n_wb, 0);
        // 2: repeat read hits with no memory traffic
        nf = n_fill;
        do_req(1'b1, 1'b0, 28'h0000010, 128'd0);
        chk("t2_no_fill", n_fill, nf);
        // 3: write hit then read back
        do_req(1'b0, 1'b1, 28'h0000010, 128'h1234);
        do_req(1'b1, 1'b0, 28'h0000010, 128'd0);
        chk("t3_readback", last_rdata, 128'h1234);
        // 4: conflict miss evicts the dirty line
        chk("t4_model_victim", {100'd0, m_tag[16], 6'd16}, 128'h10);
        chk("t4_model_dirty", {127'd0, m_dirty[16]}, 128'd1);
        do_req(1'b1, 1'b0, 28'h0000050, 128'd0);
        chk("t4_wb_addr", {100'd0, last_wb_addr}, 128'h10);
        chk("t4_wb_data", last_wb_data, 128'h1234);
        chk("t4_rdata", last_rdata, {32{4'h5}});
        // 5: clean victim goes straight to allocate
        nw = n_wb;
        do_req(1'b1, 1'b0, 28'h0000090, 128'd0);
        chk("t5_no_wb", n_wb, nw);

        // 6: reset during allocate aborts the fill
        proc_read = 1'b1;
        proc_addr = 28'h0000010;
        set_idle();
        step();
        set_exp(1'b0, 1'b1, 1'b0, 1'b1, 28'h0000010, 1'b0, 128'd0, 1'b0, 128'd0);
        @(negedge clk);
        #2;
        e_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_abort_mem_read", {127'd0, mem_read}, 128'd0);
        chk("t6_abort_ready", {127'd0, proc_ready}, 128'd0);
        proc_read = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        step();
        rst_n = 1'b1;
        set_idle();
        step();
        nf = n_fill;
        do_req(1'b1, 1'b0, 28'h0000090, 128'd0);
        chk("t6_refill", n_fill, nf + 1);

        // Randomized traffic over a few conflicting indices and tags
        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 3);
            ri = 6'($urandom_range(0, 3));
            if (ri == 6'd3) ri = 6'd16;
            rt = 22'($urandom_range(0, 3));
            do_req((r != 0), (r <= 1), {rt, ri}, {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 3) == 0) step();
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
